// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM encoding, MEM bit indices,
// and the bundle of stage-enable/flush controls with its canonical values.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Branch beats load-use: the flush already discards the dependent instruction in ID.
  function automatic ctrl_t hazard_ctrl(input logic branch_taken, input logic load_use);
    ctrl_t c;
    c = CTRL_PASS;
    if (branch_taken) begin
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
    end else if (load_use) begin
      c.pc_en       = 1'b0;
      c.ifid_en     = 1'b0;
      c.idex_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/EX-MEM and the stage controls returned to the datapath.
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt;
  logic [1:0]       exmem_mem;
  logic             branch_taken;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             dmem_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, exmem_mem, branch_taken, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
           dmem_req, mem_err, stall_cnt
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, exmem_mem, branch_taken, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
           dmem_req, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: the load in EX writes a register the ID instruction reads.
// $zero never creates a dependency.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  output logic             load_use
);

  always_comb begin
    load_use = idex_memread && (idex_rt != '0) &&
               ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, taken-branch flushes and
// data-memory waits with a timeout that halts the pipe until reset.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  hz
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic  load_use;
  logic  mem_op;
  logic  dmem_req;
  ctrl_t ctrl;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs        (hz.id_rs),
    .id_rt        (hz.id_rt),
    .id_uses_rt   (hz.id_uses_rt),
    .idex_memread (hz.idex_memread),
    .idex_rt      (hz.idex_rt),
    .load_use     (load_use)
  );

  assign mem_op = hz.exmem_mem[MEM_RD] | hz.exmem_mem[MEM_WR];

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_PASS;
    dmem_req  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        dmem_req = mem_op;
        if (mem_op && !hz.dmem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          ctrl = hazard_ctrl(hz.branch_taken, load_use);
        end
      end
      ST_MEM_WAIT: begin
        // Request stays up regardless of exmem_mem: EX/MEM is frozen, so it cannot change.
        dmem_req = 1'b1;
        if (hz.dmem_ready) begin
          ctrl    = hazard_ctrl(hz.branch_taken, load_use);
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_q >= WAIT_LAST) begin
            mem_err_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ST_HALT: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset overrides the outputs in the same cycle so a pending access is dropped at once.
    if (rst) begin
      ctrl      = CTRL_PASS;
      dmem_req  = 1'b0;
      state_d   = ST_RUN;
      wait_d    = '0;
      mem_err_d = 1'b0;
    end

    stall_d = stall_q;
    if (rst) begin
      stall_d = '0;
    end else if (!ctrl.pc_en && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    wait_q    <= wait_d;
    mem_err_q <= mem_err_d;
    stall_q   <= stall_d;
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.ifid_en     = ctrl.ifid_en;
  assign hz.idex_en     = ctrl.idex_en;
  assign hz.exmem_en    = ctrl.exmem_en;
  assign hz.memwb_en    = ctrl.memwb_en;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_bubble = ctrl.idex_bubble;
  assign hz.dmem_req    = dmem_req;
  assign hz.mem_err     = mem_err_q;
  assign hz.stall_cnt   = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the enable inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and the IF_ID flush and ID_EX bubble controls. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses through a req/ready handshake with timeout. It sits beside the datapath and takes hazard information from the ID, EX and EX/MEM stages.

Parameters:
TIMEOUT, 16, maximum cycles in MEM_WAIT before a memory error is declared (range 2..255)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt as a source
idex_memread  in  1  instruction in EX is a load
idex_rt  in  5  destination register of the instruction in EX
exmem_mem  in  2  MEM control bits in EX/MEM; [1]=MemRead, [0]=MemWrite
branch_taken  in  1  branch/jump resolved taken in EX this cycle
dmem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF_ID en_reg
idex_en  out  1  ID_EX en_reg
exmem_en  out  1  EX_MEM en_reg
memwb_en  out  1  MEM_WB en_reg
ifid_flush  out  1  load NOP into IF_ID on the next edge
idex_bubble  out  1  zero the control fields loaded into ID_EX on the next edge
dmem_req  out  1  data-memory access request
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. On reset: state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
- While rst is high, outputs take these values: all *_en=1, ifid_flush=0, idex_bubble=0, dmem_req=0.
- All control outputs are combinational from state and inputs. Only the state, wait counter, mem_err and stall_cnt are registered.
- FSM states: RUN, MEM_WAIT, HALT.
- mem_op = (exmem_mem != 0).
- RUN:
  - dmem_req=mem_op.
  - If mem_op and !dmem_ready: freeze the whole pipeline (all *_en=0, no flush/bubble); next state MEM_WAIT; wait counter=1.
  - Otherwise (no mem op, or ready in the same cycle): apply hazard rules in priority order:
    1. branch_taken: all *_en=1, ifid_flush=1, idex_bubble=1.
    2. load-use: idex_memread && idex_rt!=0 && (idex_rt==id_rs || (id_uses_rt && idex_rt==id_rt)). Then pc_en=0, ifid_en=0, idex_bubble=1; the ID_EX, EX_MEM and MEM_WB enables stay 1. Lasts exactly one cycle, because the bubble clears idex_memread.
    3. Otherwise: all *_en=1, no flush/bubble.
- MEM_WAIT:
  - dmem_req=1 and held stable until ready (the request must not drop before ready).
  - If dmem_ready: same outputs as RUN with ready=1 (hazard rules apply in that cycle); next state RUN.
  - Else: all *_en=0, wait counter +1. When the counter reaches TIMEOUT without ready: mem_err<=1, next state HALT.
- A branch_taken or load-use condition present during a freeze is deferred, because the EX and ID contents are held. It is re-evaluated in the release cycle.
- HALT: all *_en=0, dmem_req=0, no flush/bubble. Exit only via rst.
- stall_cnt increments on every non-reset cycle with pc_en=0 and saturates at all-ones.
- Reset mid-MEM_WAIT: controller returns to RUN next cycle, dmem_req drops immediately, and the pending access is abandoned.

Decomposition:
- Shared package holds the state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2) and the MEM bit indices (MEM_RD=1, MEM_WR=0).
- One natural sub-module: hazard_detect, a combinational load-use comparator. The FSM, counters and output mux stay in the top module.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; next cycle all enables 1; stall_cnt=1.
- $zero load-use: idex_rt=0, id_rs=0, idex_memread=1 -> no stall; all enables 1.
- Memory wait: exmem_mem=2'b10, dmem_ready low for 3 cycles then high -> dmem_req=1 for 4 cycles, all *_en=0 for 3 cycles, all =1 on the ready cycle; stall_cnt=3.
- Branch vs load-use in the same cycle: branch_taken=1 with a load-use match -> ifid_flush=1, idex_bubble=1, pc_en=1.
- Timeout: exmem_mem=2'b01, ready never asserted, TIMEOUT=16 -> mem_err=1 after 16 cycles, HALT with all enables 0 until rst; after rst, mem_err=0 and state RUN.
- Reset during MEM_WAIT: rst asserted on the 2nd wait cycle -> dmem_req=0 that cycle; next cycle RUN with stall_cnt=0.
